// File: rtl/box_motion_if.sv
// Control/status bundle between the frame timing logic and box_motion.
//   master : drives frame_tick, speed, pause, restart; observes motion state
//   slave  : box_motion side; samples controls, drives box_x/box_y, color,
//            hit_x/hit_y strobes and bounce_count
interface box_motion_if;
    logic       frame_tick;
    logic [2:0] speed;
    logic       pause;
    logic       restart;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic [2:0] color;
    logic       hit_x;
    logic       hit_y;
    logic [7:0] bounce_count;

    modport master (
        output frame_tick, speed, pause, restart,
        input  box_x, box_y, color, hit_x, hit_y, bounce_count
    );

    modport slave (
        input  frame_tick, speed, pause, restart,
        output box_x, box_y, color, hit_x, hit_y, bounce_count
    );
endinterface

// File: rtl/box_motion.sv
// Bouncing-box motion engine. Once per accepted frame tick, each axis moves
// by `speed` pixels and reflects off the screen edges (clamped, not mirrored).
// A colour index advances on any bounce; bounce_count tallies axis hits.
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : box_motion_if.slave (controls in, box state/strobes out)

// One axis: position, direction bit and a one-cycle hit strobe.
// hit_nxt is the combinational hit decision for the current inputs; the
// parent gates it with the update enable to advance colour/count.
module box_motion_axis #(
    parameter int LIMIT = 608,
    parameter int INIT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       upd,
    input  logic [2:0] speed,
    output logic [9:0] pos,
    output logic       hit,
    output logic       hit_nxt
);
    logic        dir;
    logic        dir_nxt;
    logic [9:0]  pos_nxt;
    logic [10:0] pos_w;
    logic [10:0] spd_w;
    logic [10:0] sum;

    // 11-bit math: pos + 7 can never wrap before the compare.
    always_comb begin
        pos_w   = {1'b0, pos};
        spd_w   = {8'b0, speed};
        sum     = pos_w + spd_w;
        pos_nxt = pos;
        dir_nxt = dir;
        hit_nxt = 1'b0;
        if (dir) begin
            if (sum >= 11'(LIMIT)) begin
                pos_nxt = 10'(LIMIT);
                dir_nxt = 1'b0;
                hit_nxt = 1'b1;
            end else begin
                pos_nxt = sum[9:0];
            end
        end else begin
            // equality counts as a hit, so a resting box at speed 0 keeps hitting
            if (pos_w <= spd_w) begin
                pos_nxt = '0;
                dir_nxt = 1'b1;
                hit_nxt = 1'b1;
            end else begin
                pos_nxt = pos - {7'b0, speed};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= 10'(INIT);
            dir <= 1'b1;
            hit <= 1'b0;
        end else if (restart) begin
            pos <= 10'(INIT);
            dir <= 1'b1;
            hit <= 1'b0;
        end else if (upd) begin
            pos <= pos_nxt;
            dir <= dir_nxt;
            hit <= hit_nxt;
        end else begin
            hit <= 1'b0;
        end
    end
endmodule

module box_motion #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0
) (
    input logic           clk,
    input logic           rst_n,
    box_motion_if.slave   bus
);
    localparam int XMAX = H_ACTIVE - BOX_SIZE;
    localparam int YMAX = V_ACTIVE - BOX_SIZE;

    logic            upd;
    logic [1:0][9:0] pos;
    logic [1:0]      hit;
    logic [1:0]      hit_nxt;
    logic [2:0]      color;
    logic [7:0]      bounce_count;

    // restart wins over a same-cycle tick; pause swallows the tick entirely
    assign upd = bus.frame_tick & ~bus.pause & ~bus.restart;

    // axis 0 = X, axis 1 = Y
    for (genvar g = 0; g < 2; g++) begin : g_axis
        box_motion_axis #(
            .LIMIT (g == 0 ? XMAX   : YMAX),
            .INIT  (g == 0 ? X_INIT : Y_INIT)
        ) u_axis (
            .clk     (clk),
            .rst_n   (rst_n),
            .restart (bus.restart),
            .upd     (upd),
            .speed   (bus.speed),
            .pos     (pos[g]),
            .hit     (hit[g]),
            .hit_nxt (hit_nxt[g])
        );
    end

    // corner hit: count +2, colour +1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color        <= '0;
            bounce_count <= '0;
        end else if (bus.restart) begin
            color        <= '0;
            bounce_count <= '0;
        end else if (upd) begin
            bounce_count <= bounce_count + 8'(hit_nxt[0]) + 8'(hit_nxt[1]);
            color        <= color + 3'(|hit_nxt);
        end
    end

    assign bus.box_x        = pos[0];
    assign bus.box_y        = pos[1];
    assign bus.hit_x        = hit[0];
    assign bus.hit_y        = hit[1];
    assign bus.color        = color;
    assign bus.bounce_count = bounce_count;
endmodule

// File: tb/tb_box_motion.sv
// Self-checking bench for box_motion. Two instances share one stimulus
// stream: d0 uses the 640x480/32 defaults, d1 a 64x64/16 screen for the
// corner case. A per-axis reference model tracks both; every falling edge
// compares all outputs, and literal checks pin known scenarios.
module tb_box_motion;
    logic clk;
    logic rst_n;

    box_motion_if bus0 ();
    box_motion_if bus1 ();

    box_motion u_d0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    box_motion #(.H_ACTIVE(64), .V_ACTIVE(64), .BOX_SIZE(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // model state per instance
    typedef struct { int p; int d; int h; } ax_t;
    ax_t mx[2];
    ax_t my[2];
    int  mcol[2];
    int  mcnt[2];
    int  lim_x[2] = '{608, 48};
    int  lim_y[2] = '{448, 48};

    function automatic ax_t ax_step(ax_t a, int s, int lim);
        ax_t r;
        r = a;
        r.h = 0;
        if (a.d != 0) begin
            if (a.p + s >= lim) begin r.p = lim; r.d = 0; r.h = 1; end
            else r.p = a.p + s;
        end else begin
            if (a.p <= s) begin r.p = 0; r.d = 1; r.h = 1; end
            else r.p = a.p - s;
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = '{0, 1, 0};
            my[k] = '{0, 1, 0};
            mcol[k] = 0;
            mcnt[k] = 0;
        end
    endfunction

    function automatic void model_step(bit ft, int sp, bit pa, bit rs);
        for (int k = 0; k < 2; k++) begin
            mx[k].h = 0;
            my[k].h = 0;
            if (rs) begin
                mx[k] = '{0, 1, 0};
                my[k] = '{0, 1, 0};
                mcol[k] = 0;
                mcnt[k] = 0;
            end else if (ft && !pa) begin
                mx[k] = ax_step(mx[k], sp, lim_x[k]);
                my[k] = ax_step(my[k], sp, lim_y[k]);
                mcnt[k] = (mcnt[k] + mx[k].h + my[k].h) % 256;
                if (mx[k].h != 0 || my[k].h != 0) mcol[k] = (mcol[k] + 1) % 8;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input int k, input int x, input int y, input int c,
                           input int hx, input int hy, input int cnt);
        string p;
        p = (k == 0) ? "d0" : "d1";
        chk({p, ".box_x"}, x, mx[k].p);
        chk({p, ".box_y"}, y, my[k].p);
        chk({p, ".color"}, c, mcol[k]);
        chk({p, ".hit_x"}, hx, mx[k].h);
        chk({p, ".hit_y"}, hy, my[k].h);
        chk({p, ".bounce_count"}, cnt, mcnt[k]);
    endtask

    // continuous compare against the model
    always @(negedge clk) begin
        chk_dut(0, bus0.box_x, bus0.box_y, bus0.color, bus0.hit_x, bus0.hit_y, bus0.bounce_count);
        chk_dut(1, bus1.box_x, bus1.box_y, bus1.color, bus1.hit_x, bus1.hit_y, bus1.bounce_count);
    end

    // drive one cycle of controls on both instances; returns after the next negedge
    task automatic cyc(input bit ft, input logic [2:0] sp, input bit pa, input bit rs);
        bus0.frame_tick = ft; bus0.speed = sp; bus0.pause = pa; bus0.restart = rs;
        bus1.frame_tick = ft; bus1.speed = sp; bus1.pause = pa; bus1.restart = rs;
        @(posedge clk);
        if (rst_n) model_step(ft, int'(sp), pa, rs);
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input logic [2:0] sp);
        for (int i = 0; i < n; i++) cyc(1'b1, sp, 1'b0, 1'b0);
    endtask

    // one-cycle async reset pulse placed between clock edges
    task automatic rst_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.async_x", bus0.box_x, 0);
        chk("rst.async_cnt", bus0.bounce_count, 0);
        chk("rst.async_col", bus0.color, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        bus0.frame_tick = 0; bus0.speed = 0; bus0.pause = 0; bus0.restart = 0;
        bus1.frame_tick = 0; bus1.speed = 0; bus1.pause = 0; bus1.restart = 0;

        // ticks during reset are ignored
        ticks(3, 3'd3);
        chk("reset.box_x", bus0.box_x, 0);
        chk("reset.box_y", bus0.box_y, 0);
        chk("reset.hit_x", bus0.hit_x, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'd5, 1'b0, 1'b0);
        chk("idle.box_x", bus0.box_x, 0);
        chk("idle.bounce_count", bus0.bounce_count, 0);

        // straight motion
        ticks(10, 3'd3);
        chk("straight.box_x", bus0.box_x, 30);
        chk("straight.box_y", bus0.box_y, 30);
        chk("straight.bounce_count", bus0.bounce_count, 0);

        // pause then speed 0 away from edges
        for (int i = 0; i < 5; i++) cyc(1'b1, 3'(i + 1), 1'b1, 1'b0);
        chk("pause.box_x", bus0.box_x, 30);
        chk("pause.box_y", bus0.box_y, 30);
        ticks(3, 3'd0);
        chk("speed0.box_x", bus0.box_x, 30);
        chk("speed0.hit_y", bus0.hit_y, 0);

        // restart beats a same-cycle tick
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        ticks(20, 3'd5);
        chk("pre_restart.box_x", bus0.box_x, 100);
        cyc(1'b1, 3'd5, 1'b0, 1'b1);
        chk("restart.box_x", bus0.box_x, 0);
        chk("restart.box_y", bus0.box_y, 0);
        chk("restart.color", bus0.color, 0);
        chk("restart.hit_x", bus0.hit_x, 0);
        ticks(1, 3'd1);
        chk("restart.dx", bus0.box_x, 1);
        chk("restart.dy", bus0.box_y, 1);

        // edge clamp and reflect
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        ticks(64, 3'd7);
        chk("edge64.box_y", bus0.box_y, 448);
        chk("edge64.hit_y", bus0.hit_y, 1);
        chk("edge64.hit_x", bus0.hit_x, 0);
        chk("edge64.color", bus0.color, 1);
        chk("edge64.bounce_count", bus0.bounce_count, 1);
        ticks(1, 3'd7);
        chk("edge65.box_y", bus0.box_y, 441);
        chk("edge65.box_x", bus0.box_x, 455);
        chk("edge65.hit_y", bus0.hit_y, 0);
        ticks(22, 3'd7);
        chk("edge87.box_x", bus0.box_x, 608);
        chk("edge87.box_y", bus0.box_y, 287);
        chk("edge87.hit_x", bus0.hit_x, 1);
        chk("edge87.color", bus0.color, 2);
        chk("edge87.bounce_count", bus0.bounce_count, 2);

        // corner on the small screen
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        ticks(12, 3'd4);
        chk("corner.box_x", bus1.box_x, 48);
        chk("corner.box_y", bus1.box_y, 48);
        chk("corner.hit_x", bus1.hit_x, 1);
        chk("corner.hit_y", bus1.hit_y, 1);
        chk("corner.bounce_count", bus1.bounce_count, 2);
        chk("corner.color", bus1.color, 1);
        ticks(1, 3'd4);
        chk("corner13.box_x", bus1.box_x, 44);
        chk("corner13.box_y", bus1.box_y, 44);

        // mid-run asynchronous reset
        ticks(5, 3'd6);
        rst_pulse();
        chk("rst.box_y", bus0.box_y, 0);

        // randomized run, model-checked every cycle
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) rst_pulse();
            else cyc($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
